// File: rtl/envelope_shaper.sv
// envelope_shaper
//   ADSR amplitude envelope applied to the raw 8-bit unsigned sine sample.
//   Everything runs in the CLK_32KHz domain, one sample per clock.
//
//   Optional build macro: ENVELOPE_ZERO_SYNC_EN
//     defined   -> note start / retrigger (IDLE->ATTACK, RELEASE->ATTACK)
//                  waits for indexZero=1 so the note begins at the trough.
//     undefined -> note starts on the first cycle noteOn=1; indexZero ignored.
//
// Ports:
//   CLK_32KHz     in   sample clock
//   reset_n       in   asynchronous active-low reset
//   noteOn        in   note gate, level-sensitive (1 = key held)
//   inputSample   in   [7:0] unsigned sine sample (0 = trough)
//   indexZero     in   generator at table index 0
//   outputSample  out  [7:0] enveloped sample, registered (1 clock latency)
//   envelopeLevel out  [7:0] current envelope level
//   envState      out  [2:0] 0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
//   active        out  high whenever envState != IDLE
module envelope_shaper #(
    parameter int TICK_DIV      = 32,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       CLK_32KHz,
    input  logic       reset_n,
    input  logic       noteOn,
    input  logic [7:0] inputSample,
    input  logic       indexZero,
    output logic [7:0] outputSample,
    output logic [7:0] envelopeLevel,
    output logic [2:0] envState,
    output logic       active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [9:0] TICK_LAST   = 10'(TICK_DIV - 1);
    localparam logic [7:0] ATTACK_INC  = 8'(ATTACK_STEP);
    localparam logic [7:0] DECAY_DEC   = 8'(DECAY_STEP);
    localparam logic [7:0] RELEASE_DEC = 8'(RELEASE_STEP);
    localparam logic [7:0] SUSTAIN_LVL = 8'(SUSTAIN_LEVEL);

    // 9-bit add; carry out means the level would pass full scale.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // 9-bit subtract; borrow (bit 8) or undershoot clamps to the floor.
    function automatic logic [7:0] floor_sub(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] floor_lvl);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[8] || (diff[7:0] < floor_lvl))
            return floor_lvl;
        return diff[7:0];
    endfunction

    env_state_t  state_q, state_d;
    logic [7:0]  level_q, level_d;
    logic [9:0]  tick_cnt;
    logic        tick;
    logic        start_ok;
    logic [8:0]  level_inc;
    logic [16:0] prod_p0;
    logic [7:0]  out_p1;

`ifdef ENVELOPE_ZERO_SYNC_EN
    assign start_ok = noteOn && indexZero;
`else
    logic index_zero_unused;
    assign index_zero_unused = indexZero;
    assign start_ok          = noteOn;
`endif

    // Free-running divider; gate activity never touches it.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 10'd1;
    end

    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // Gate-driven transitions are tested first so they win over a tick:
    // the state moves and the level is left alone that cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                level_d = '0;
                if (start_ok)
                    state_d = ATTACK;
            end
            ATTACK: begin
                if (!noteOn) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    level_d = sat_add(level_q, ATTACK_INC);
                    if (level_d == 8'hFF)
                        state_d = DECAY;
                end
            end
            DECAY: begin
                if (!noteOn) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    level_d = floor_sub(level_q, DECAY_DEC, SUSTAIN_LVL);
                    if (level_d == SUSTAIN_LVL)
                        state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!noteOn)
                    state_d = RELEASE;
            end
            RELEASE: begin
                // Retrigger keeps the current level; no drop to zero.
                if (start_ok) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    level_d = floor_sub(level_q, RELEASE_DEC, 8'd0);
                    if (level_d == 8'd0)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
            end
        endcase
    end

    // ---- stage p0: sample x (level+1); 255*256 fits in 17 bits ----
    assign level_inc = {1'b0, level_q} + 9'd1;
    assign prod_p0   = {9'd0, inputSample} * {8'd0, level_inc};

    // ---- stage p1: registered output ----
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n)
            out_p1 <= '0;
        else if (state_q == IDLE)
            out_p1 <= '0;
        else
            out_p1 <= 8'(prod_p0 >> 8);
    end

    assign outputSample  = out_p1;
    assign envelopeLevel = level_q;
    assign envState      = state_q;
    assign active        = (state_q != IDLE);

endmodule
